// File: rtl/spi_cfg_regbank.sv
// rtl/spi_cfg_regbank.sv - addressed SPI config register bank with shadow/commit, trigger and write mute
// Optional readback (miso port, read frames) is enabled by defining SPI_READBACK_EN.
module spi_cfg_regbank #(
    parameter int NUM_REGS    = 8,
    parameter int REG_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sclk_i,
    input  logic                      mosi_i,
    input  logic                      nss_i,
    output logic [NUM_REGS*REG_W-1:0] cfg_out_o,
    output logic                      mute_o,
`ifdef SPI_READBACK_EN
    output logic                      trig_o,
    output logic                      miso_o
`else
    output logic                      trig_o
`endif
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(REG_W);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_IGNORE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, nss_sync_q;
    logic                   sclk_prev_q, nss_prev_q;
    logic                   sclk_s, mosi_s, nss_s;
    logic                   sclk_rise, nss_rise, nss_fall;

    logic [6:0]       cmd_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [AW-1:0]    addr_q, addr_next;
    logic [REG_W-2:0] data_sh_q;
    logic             wr_q, tr_q, have_word_q;
    logic             armed_q, mute_q, trig_q, commit_q;
    logic [REG_W-1:0] shadow_q [NUM_REGS];
    logic [REG_W-1:0] cfg_q    [NUM_REGS];

    logic [7:0] cmd_byte;
    logic [5:0] cmd_addr;
    logic       addr_ok, cmd_done, word_done;
    logic       cmd_wr, cmd_tr, cmd_valid;
    logic       commit_d, trig_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign nss_s     = nss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign nss_rise  = nss_s & ~nss_prev_q;
    assign nss_fall  = ~nss_s & nss_prev_q;

    assign cmd_byte  = {cmd_q, mosi_s};
    assign cmd_addr  = cmd_byte[5:0];
    assign addr_ok   = {1'b0, cmd_addr} < 7'(NUM_REGS);
    assign cmd_wr    = cmd_byte[7] & addr_ok;
    assign cmd_tr    = ~cmd_byte[7] & cmd_byte[6];
    assign cmd_done  = (state_q == S_CMD) && sclk_rise && (bit_cnt_q == CW'(7));
    assign word_done = (state_q == S_DATA) && sclk_rise && (bit_cnt_q == CW'(REG_W - 1));
    assign addr_next = (addr_q == AW'(NUM_REGS - 1)) ? '0 : addr_q + AW'(1);

`ifdef SPI_READBACK_EN
    logic cmd_rd, rd_q;
    assign cmd_rd    = ~cmd_byte[7] & ~cmd_byte[6] & addr_ok;
    assign cmd_valid = cmd_wr | cmd_tr | cmd_rd;
`else
    assign cmd_valid = cmd_wr | cmd_tr;
`endif

    // A final sclk edge arriving with the nss rise is taken first, so a word it completes still commits.
    assign commit_d = nss_rise && (state_q == S_DATA) && wr_q && (have_word_q || word_done);
    assign trig_d   = nss_rise && (((state_q == S_DATA) && tr_q) || (cmd_done && cmd_tr));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (nss_fall && armed_q) state_d = S_CMD;
            S_CMD:   if (cmd_done) state_d = cmd_valid ? S_DATA : S_IGNORE;
            default: ;
        endcase
        if (nss_rise) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            nss_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            nss_prev_q  <= 1'b0;
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            data_sh_q   <= '0;
            wr_q        <= 1'b0;
            tr_q        <= 1'b0;
            have_word_q <= 1'b0;
            armed_q     <= 1'b0;
            mute_q      <= 1'b0;
            trig_q      <= 1'b0;
            commit_q    <= 1'b0;
`ifdef SPI_READBACK_EN
            rd_q        <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                cfg_q[i]    <= '0;
            end
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss_i};
            sclk_prev_q <= sclk_s;
            nss_prev_q  <= nss_s;
            state_q     <= state_d;
            armed_q     <= armed_q | nss_s;
            commit_q    <= commit_d;
            trig_q      <= trig_d;

            if (commit_q) begin
                for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= shadow_q[i];
                mute_q <= 1'b0;
            end
            if (nss_rise && !commit_d) mute_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    bit_cnt_q   <= '0;
                    have_word_q <= 1'b0;
                end
                S_CMD: if (sclk_rise) begin
                    cmd_q     <= cmd_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (cmd_done) begin
                        bit_cnt_q <= '0;
                        addr_q    <= cmd_addr[AW-1:0];
                        wr_q      <= cmd_wr;
                        tr_q      <= cmd_tr;
`ifdef SPI_READBACK_EN
                        rd_q      <= cmd_rd;
`endif
                        // Shadow may hold leftovers of an aborted frame; resync it before writing.
                        if (cmd_wr) begin
                            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= cfg_q[i];
                            mute_q <= !nss_rise;
                        end
                    end
                end
                S_DATA: if (sclk_rise) begin
                    data_sh_q <= {data_sh_q[REG_W-3:0], mosi_s};
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (word_done) begin
                        bit_cnt_q   <= '0;
                        addr_q      <= addr_next;
                        have_word_q <= 1'b1;
                        if (wr_q) shadow_q[addr_q] <= {data_sh_q, mosi_s};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic             sclk_fall, miso_q;
    logic [REG_W-1:0] rd_word;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rd_word   = cfg_q[addr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || nss_rise || (state_q != S_DATA) || !rd_q) begin
            miso_q <= 1'b0;
        end else if (sclk_fall) begin
            miso_q <= rd_word[CW'(REG_W - 1) - bit_cnt_q];
        end
    end
    assign miso_o = miso_q;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign cfg_out_o[g*REG_W +: REG_W] = cfg_q[g];
    end

    assign mute_o = mute_q;
    assign trig_o = trig_q;

endmodule

// File: doc/spi_cfg_regbank.md
Name: spi_cfg_regbank

Overview:
Parametrised successor to the synth's SPI configuration shift register. It holds NUM_REGS addressed registers of REG_W bits, written through an addressed, auto-incrementing SPI write protocol. SCLK, MOSI and NSS are oversampled in the system clock domain. Writes land in shadow registers and commit atomically to the live outputs on NSS deassert. Live outputs drive ADSR, oscillator and filter config. The block also provides an SPI-issued trigger pulse and a mute that covers only write frames.

Parameters:
NUM_REGS, 8, number of config registers; 2..64
REG_W, 8, register width in bits; 8..16
SYNC_STAGES, 2, synchroniser flops on sclk/mosi/nss; >=2

Ports:
clk  in  1  system clock; must run at >= 4x sclk
rst  in  1  synchronous, active-high reset
sclk  in  1  SPI clock, mode 0 (idle low, sample on rising edge)
mosi  in  1  SPI data, MSB first
nss  in  1  SPI chip select, active low
cfg_out  out  NUM_REGS*REG_W  live registers; reg i = cfg_out[i*REG_W +: REG_W]
mute  out  1  high while a write frame is in progress
trig  out  1  one-clk trigger pulse
miso  out  1  readback data; port present only with SPI_READBACK_EN

Behaviour:
- Reset: shadow regs = 0, cfg_out = 0, mute = 0, trig = 0, miso = 0, FSM = IDLE, armed = 0.
  - Reset applied mid-frame aborts the frame with no commit.
  - After reset, a frame is accepted only after synchronised nss has been seen high (armed = 1).
- Input path: SYNC_STAGES flops on each input, plus one edge-detect register on sclk and nss.
  - All frame logic acts on synchronised sclk rising/falling pulses and nss fall/rise pulses.
- Frame format:
  - First 8 bits form the command: bit7 = W, bit6 = T, bits[5:0] = start address A.
  - Then any number of REG_W-bit data words.
- Command decode:
  - W=1: write frame. A >= NUM_REGS marks the frame invalid; all words are ignored, with no mute and no commit.
  - W=0, T=1: trigger frame; data bits are ignored.
  - W=0, T=0: read frame (with feature) or NOP (without feature).
- FSM states: IDLE, CMD, DATA, IGNORE.
  - IDLE -> CMD: nss fall while armed.
  - CMD -> DATA: 8th bit received and command is a valid write, trigger or read.
  - CMD -> IGNORE: 8th bit received and command is an invalid write or a NOP.
  - Any state -> IDLE: nss rise.
  - nss rise during CMD: command discarded, no effects.
- Bit counter: counts 0..7 in CMD and 0..REG_W-1 in DATA.
- Write words: each completed word is stored to shadow[addr].
  - addr starts at A and increments after each word.
  - NUM_REGS-1 wraps to 0.
  - A later word to the same address overwrites the earlier one.
- Commit: on nss rise ending a valid write frame with >= 1 complete word, all shadow regs are copied to cfg_out in the cycle after the rise is detected.
  - Partial trailing words are discarded.
  - Frames with zero complete words do not commit.
  - Shadow regs always equal cfg_out outside a write frame: at the start of every write frame, shadow is reloaded from cfg_out.
- mute:
  - Asserted the cycle after the command byte decodes as a valid write.
  - Deasserted in the same cycle cfg_out commits, or at nss rise if nothing commits.
- trig: 1-clk pulse in the cycle after nss rise of a trigger frame whose command byte completed. Never asserts mute.
- Latency: nss pin rise to cfg_out update is SYNC_STAGES+2 clk.
- Simultaneous nss rise and the last sclk rise in the same clk: the sclk edge is processed first, so the word counts.

Optional Feature:
Macro SPI_READBACK_EN.
- With the macro:
  - Port miso exists.
  - A read frame (W=0, T=0, A < NUM_REGS) shifts cfg_out[addr] out MSB first, auto-incrementing with the same wrap rule.
  - miso changes on synchronised sclk falling pulses. The first bit is valid after the falling edge that follows the 8th command bit.
  - miso = 0 when nss is high, and for A >= NUM_REGS.
- Without the macro: no miso port, and read frames are NOPs (IGNORE state).

Test Plan:
(NUM_REGS=8, REG_W=8, sclk = clk/8)
- Reset value: rst high for 3 clk -> cfg_out=0, mute=0, trig=0. Then a frame issued without nss having gone high since reset -> no effect.
- Write with wrap-around: frame 0x86, 0x11, 0x22, 0x33 -> after nss rise, reg6=0x11, reg7=0x22, reg0=0x33, others unchanged. mute high from command decode until the commit cycle. Commit lands SYNC_STAGES+2 clk after nss rise.
- Atomicity and partial word: frame 0x80, 0xAA, then 5 bits -> cfg_out unchanged mid-frame; after nss rise reg0=0xAA, reg1 unchanged.
- Trigger frame: frame 0x40 -> trig high exactly 1 clk after nss rise, mute stays 0, cfg_out unchanged.
- Aborts and invalid addresses:
  - Frame 0x89, 0x55 (addr 9) -> no commit, mute stays 0.
  - rst asserted during data of 0x80, 0x77 -> reg0=0 after reset.
- Readback (SPI_READBACK_EN): write reg3=0x5C, then frame 0x03 + 8 clocks -> miso reads 0x5C MSB first.
